// File: rtl/gate_selftest_pkg.sv
// gate_selftest_pkg: shared state encoding, truth-table constants and mismatch helper for gate_selftest_ctrl
package gate_selftest_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int unsigned CNT_W = 4;
  localparam logic [3:0] NOR_TT  = 4'b0001;
  localparam logic [3:0] OR_TT   = 4'b1110;
  localparam logic [3:0] AND_TT  = 4'b1000;
  localparam logic [3:0] NAND_TT = 4'b0111;
  localparam logic [3:0] XOR_TT  = 4'b0110;
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : v[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/gate_selftest_ctrl_if.sv
// gate_selftest_ctrl_if: lab-side and gate-side signals of the self-test controller; GATE_SELFTEST_FAIL_IDX_EN adds mismatch-index outputs
interface gate_selftest_ctrl_if;
  logic       start;
  logic [3:0] expected;
  logic       gate_out;
  logic       input1;
  logic       input2;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] observed;
`ifdef GATE_SELFTEST_FAIL_IDX_EN
  logic       fail_valid;
  logic [1:0] fail_idx;
  modport master (output start, expected, gate_out,
                  input input1, input2, busy, done, pass, observed, fail_valid, fail_idx);
  modport slave (input start, expected, gate_out,
                 output input1, input2, busy, done, pass, observed, fail_valid, fail_idx);
`else
  modport master (output start, expected, gate_out,
                  input input1, input2, busy, done, pass, observed);
  modport slave (input start, expected, gate_out,
                 output input1, input2, busy, done, pass, observed);
`endif
endinterface

// File: rtl/gate_selftest_ctrl_settle_timer.sv
// settle_timer: down-counter pulsing expire every SETTLE_CYCLES+1 enabled cycles, reloading while disabled
module settle_timer
  import gate_selftest_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expire
);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign expire = en && cnt_q == '0;
  always_comb cnt_d = (!en || expire) ? RELOAD : cnt_q - CNT_W'(1);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= RELOAD;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/gate_selftest_ctrl.sv
// gate_selftest_ctrl: walks a 2-input gate through all four vectors and checks its truth table
// Optional macro GATE_SELFTEST_FAIL_IDX_EN adds fail_valid/fail_idx reporting.
module gate_selftest_ctrl
  import gate_selftest_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  gate_selftest_ctrl_if.slave bus
);
  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] obs_q, obs_d, exp_q, exp_d;
  logic       pass_q, pass_d, done_q, busy_q, in1_q, in2_q;
  logic       expire;
  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == RUN),
    .expire (expire)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    obs_d   = obs_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        idx_d   = 2'd0;
        obs_d   = 4'd0;
        pass_d  = 1'b0;
        exp_d   = bus.expected;
      end
      RUN: if (expire) begin
        obs_d[idx_q] = bus.gate_out;
        idx_d        = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // compare at the DONE entry so pass is already valid alongside done
    if (state_q == RUN && state_d == DONE) pass_d = obs_d == exp_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      obs_q   <= 4'd0;
      exp_q   <= 4'd0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      in1_q   <= 1'b0;
      in2_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      obs_q          <= obs_d;
      exp_q          <= exp_d;
      pass_q         <= pass_d;
      done_q         <= state_d == DONE;
      busy_q         <= state_d == RUN;
      {in1_q, in2_q} <= state_d == RUN ? idx_d : 2'b00;
    end
  end
  assign bus.input1   = in1_q;
  assign bus.input2   = in2_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.observed = obs_q;
`ifdef GATE_SELFTEST_FAIL_IDX_EN
  logic       fv_q, fv_d;
  logic [1:0] fi_q, fi_d;
  always_comb begin
    fv_d = fv_q;
    fi_d = fi_q;
    if (state_q == IDLE && bus.start) begin
      fv_d = 1'b0;
      fi_d = 2'd0;
    end else if (state_q == RUN && state_d == DONE) begin
      fv_d = |(obs_d ^ exp_q);
      fi_d = lowest_set(obs_d ^ exp_q);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q <= 1'b0;
      fi_q <= 2'd0;
    end else begin
      fv_q <= fv_d;
      fi_q <= fi_d;
    end
  end
  assign bus.fail_valid = fv_q;
  assign bus.fail_idx   = fi_q;
`endif
endmodule

// File: doc/gate_selftest_ctrl.md
# gate_selftest_ctrl

Sequencing controller for a 2-input combinational gate under test (NOR, AND, OR and similar lab gates). On a `start` pulse it drives all four input combinations onto the gate and holds each one for a programmable settle time. It samples the gate output into a 4-bit observed truth table and compares that table against an expected table. It sits between the lab top-level, which provides the start/expected/result interface, and the gate instance, which it drives and observes.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- `clk`  in  1: single clock, rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a test run; accepted only in IDLE.
- `expected`  in  4: expected truth table, bit k = gate output for vector k; latched on accepted start.
- `gate_out`  in  1: output of the gate under test.
- `input1`  out  1: gate input 1 = vector index bit 1.
- `input2`  out  1: gate input 2 = vector index bit 0.
- `busy`  out  1: high while vectors are being applied.
- `done`  out  1: one-cycle pulse when the result is valid.
- `pass`  out  1: observed == expected, valid from `done` until the next accepted start.
- `observed`  out  4: captured truth table.

## Operation
- States:
  - IDLE: all outputs idle.
  - RUN: vectors applied.
  - DONE: result published.
- IDLE → RUN on `start`=1. On acceptance:
  - `idx`←0, `cnt`←0.
  - `observed`←0, `pass`←0.
  - `expected` latched internally.
- In RUN, `input1`=`idx[1]` and `input2`=`idx[0]`, applied in order 00, 01, 10, 11.
- Each RUN cycle:
  - If `cnt`==SETTLE_CYCLES: `observed[idx]`←`gate_out`, `cnt`←0, `idx`←`idx`+1.
  - Otherwise `cnt`←`cnt`+1.
- After the capture at `idx`=3, go to DONE. `idx` wraps to 0 and does not advance further.
- DONE (exactly one cycle):
  - `done`=1.
  - `pass` is registered as (`observed` == latched `expected`); the full 4-bit `observed` is used, including the final capture.
  - Next state is IDLE.
- `start` is ignored in RUN and DONE; it carries no queueing.
- `start` held high continuously restarts a run each time the controller returns to IDLE.
- `input1`/`input2` are 0 in IDLE and DONE.
- Reset values: `input1`=0, `input2`=0, `busy`=0, `done`=0, `pass`=0, `observed`=0, state=IDLE.
- Reset mid-run aborts immediately: outputs return to their reset values on the next edge, and the partial `observed` is discarded.
- The expected table for NOR is 4'b0001 (only vector 00 gives 1).

## Timing
- Start accepted at edge 0 → RUN and `busy`=1 from edge 1.
- Each vector is held SETTLE_CYCLES+1 cycles. `gate_out` is sampled at the last edge of that window.
- `done`=1 in the cycle following edge 1+4·(SETTLE_CYCLES+1).
  - SETTLE_CYCLES=1: `done` after edge 9.
  - SETTLE_CYCLES=0: `done` after edge 5.
- `busy` and `done` are never high together.
- `pass` and `observed` are stable from `done` until the next accepted start or `rst`.
- All outputs are registered; there is no combinational path from `gate_out` or `start` to any output.

## Configuration
- Macro `GATE_SELFTEST_FAIL_IDX_EN`.
- Defined: adds two extra outputs.
  - `fail_valid` (1 bit): 1 when any bit mismatches.
  - `fail_idx` (2 bits): lowest mismatching vector index.
  - Both are updated in the DONE cycle, cleared on accepted start, and reset to 0.
- Undefined: neither port exists and no mismatch-index logic is generated. All other behaviour is identical.

## Structure
- Package `gate_selftest_pkg` holds:
  - The state enum (IDLE, RUN, DONE).
  - Truth-table constants: NOR_TT=4'b0001, OR_TT=4'b1110, AND_TT=4'b1000, NAND_TT=4'b0111, XOR_TT=4'b0110.
- One sub-module, `settle_timer`: a parameterised down-counter giving a one-cycle `expire` every SETTLE_CYCLES+1 cycles while enabled. Its count reloads when enable is low.
- The FSM, vector index, capture register and comparator live in `gate_selftest_ctrl`.

## Test plan
All scenarios use SETTLE_CYCLES=1 unless stated.
- Behavioural NOR on `gate_out`, `expected`=NOR_TT, start at edge 0 → `done` after edge 9, `pass`=1, `observed`=4'b0001.
- `gate_out` tied 0, `expected`=4'b0001 → `pass`=0, `observed`=4'b0000. With `GATE_SELFTEST_FAIL_IDX_EN`: `fail_valid`=1, `fail_idx`=0.
- Monitor `input1`/`input2` during RUN → 00, 01, 10, 11, each held exactly 2 cycles, then 00 in DONE; `busy` high for exactly 8 cycles.
- Extra `start` pulses during RUN and during DONE → ignored, single `done`. A start in IDLE afterwards clears `observed` to 0 and produces a fresh `done` 9 cycles later.
- `rst`=1 at edge 4 of a run → after that edge: `busy`=0, `input1`=`input2`=0, `observed`=0, no `done`. A subsequent NOR run passes.
- SETTLE_CYCLES=0 with behavioural OR, `expected`=OR_TT → `done` after edge 5, `pass`=1, `observed`=4'b1110.
